// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU.
// Covers the alu_op encoding, the branch-flag selector, the FSM state
// encoding and the bit positions of the registered flag set {C,V,S,Z}.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_Z = 2'b00,
        BR_S = 2'b01,
        BR_V = 2'b10,
        BR_C = 2'b11
    } branch_sel_e;

    // ST_MUL is only ever entered when the multiplier is built in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_MUL   = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

endpackage

// File: rtl/alu_arith.sv
// alu_arith: single-cycle add/sub/and/xor with Z/S/V/C flag generation.
// Purely combinational; the caller decides whether the flags are kept.
import alu_pkg::*;

module alu_arith #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;

    // Select the result and derive the flags; C is carry for ADD and
    // unsigned borrow for SUB, V is two's-complement overflow.
    always_comb begin
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result        = sum_ext[WIDTH-1:0];
                flags[FLAG_C] = sum_ext[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) &&
                                (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result        = diff;
                flags[FLAG_C] = (a < b);
                flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) &&
                                (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_S] = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Single-cycle add/sub/logic, one-bit-
// per-cycle shifts, registered Z/S/V/C flags feeding a branch condition.
// Optional feature macro: ALU_MUL_EN builds the iterative shift-add
// multiplier for op 111; without it op 111 returns out_err=1, out_val=0.
import alu_pkg::*;

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       alu_op,
    input  logic [1:0]       branch_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic             out_err,
    output logic [3:0]       flags_q,
    output logic             out_cond
);

    // Shift amounts at or above this value saturate without iterating.
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             err_reg, err_next;
    logic [3:0]       flags_reg, flags_next;
    alu_op_e          op_reg, op_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;

    alu_op_e          op_in;
    logic [WIDTH-1:0] arith_res;
    logic [3:0]       arith_flags;

`ifdef ALU_MUL_EN
    localparam logic [SHW:0] MUL_CYCLES = (SHW+1)'(WIDTH);

    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [SHW:0]     mcnt_reg, mcnt_next;
`endif

    assign op_in = alu_op_e'(alu_op);

    alu_arith #(.WIDTH(WIDTH)) u_arith (
        .a      (in1),
        .b      (in2),
        .op     (op_in),
        .result (arith_res),
        .flags  (arith_flags)
    );

    // One-bit step of the iterative shifter; the latched op picks direction.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input alu_op_e op);
        case (op)
            OP_SHL:  return {v[WIDTH-2:0], 1'b0};
            OP_SHR:  return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and datapath: latch at accept, iterate, hold in DONE.
    always_comb begin
        state_next  = state_reg;
        res_next    = res_reg;
        err_next    = err_reg;
        flags_next  = flags_reg;
        op_next     = op_reg;
        cnt_next    = cnt_reg;
`ifdef ALU_MUL_EN
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        mcnt_next   = mcnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    op_next  = op_in;
                    err_next = 1'b0;
                    case (op_in)
                        OP_ADD, OP_SUB: begin
                            res_next   = arith_res;
                            flags_next = arith_flags;
                            state_next = ST_DONE;
                        end
                        OP_AND, OP_XOR: begin
                            res_next   = arith_res;
                            state_next = ST_DONE;
                        end
                        OP_SHL, OP_SHR, OP_SRA: begin
                            if (in2 >= WIDTH_V) begin
                                res_next   = (op_in == OP_SRA) ? {WIDTH{in1[WIDTH-1]}} : '0;
                                state_next = ST_DONE;
                            end else if (in2 == '0) begin
                                res_next   = in1;
                                state_next = ST_DONE;
                            end else begin
                                res_next   = in1;
                                cnt_next   = in2[SHW-1:0];
                                state_next = ST_SHIFT;
                            end
                        end
                        default: begin
`ifdef ALU_MUL_EN
                            res_next    = '0;
                            mcand_next  = in1;
                            mplier_next = in2;
                            mcnt_next   = MUL_CYCLES;
                            state_next  = ST_MUL;
`else
                            res_next    = '0;
                            err_next    = 1'b1;
                            state_next  = ST_DONE;
`endif
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                res_next = shift_one(res_reg, op_reg);
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == SHW'(1)) state_next = ST_DONE;
            end
            ST_MUL: begin
`ifdef ALU_MUL_EN
                // One partial product per cycle; only the low WIDTH bits matter.
                if (mplier_reg[0]) res_next = res_reg + mcand_reg;
                mcand_next  = {mcand_reg[WIDTH-2:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
                mcnt_next   = mcnt_reg - 1'b1;
                if (mcnt_reg == (SHW+1)'(1)) state_next = ST_DONE;
`else
                state_next = ST_IDLE;
`endif
            end
            default: begin
                if (out_ready) state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_reg    <= '0;
            err_reg    <= 1'b0;
            flags_reg  <= '0;
            op_reg     <= OP_ADD;
            cnt_reg    <= '0;
`ifdef ALU_MUL_EN
            mcand_reg  <= '0;
            mplier_reg <= '0;
            mcnt_reg   <= '0;
`endif
        end else begin
            res_reg    <= res_next;
            err_reg    <= err_next;
            flags_reg  <= flags_next;
            op_reg     <= op_next;
            cnt_reg    <= cnt_next;
`ifdef ALU_MUL_EN
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            mcnt_reg   <= mcnt_next;
`endif
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign out_val   = res_reg;
    assign out_err   = err_reg;
    assign flags_q   = flags_reg;
    assign out_cond  = flags_reg[branch_sel];

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU. Executes one operation at a time on WIDTH-bit operands: single-cycle add/sub/logic, iterative multi-cycle shifts (including arithmetic right shift), and an optional iterative multiplier. Keeps a registered flag set (Z/S/V/C) that drives branch-condition evaluation. Sits between the register-file read stage and writeback; valid/ready on both sides lets a multi-cycle op stall the pipeline.

## Interface
- WIDTH, 8: operand and result width, at least 4.
- SHW, $clog2(WIDTH): width of the shift counter. Derived; do not override.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- in1, in2  in  WIDTH  operands; in2 supplies the shift amount for shifts.
- alu_op  in  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SHL, 101 SHR, 110 SRA, 111 MUL.
- branch_sel  in  2  selects a flag for out_cond: 00 Z, 01 S, 10 V, 11 C.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_val  out  WIDTH  result.
- out_err  out  1  illegal op; qualified by out_valid.
- flags_q  out  4  registered {C,V,S,Z}.
- out_cond  out  1  combinational; equals flags_q[branch_sel].

## Operation
- FSM states are IDLE, SHIFT, MUL and DONE. in_ready = (state==IDLE).
- Accept on in_valid && in_ready. Operands and op are latched at accept.
- ADD, SUB, AND and XOR compute at accept and go to DONE.
- SHL, SHR and SRA with in2 >= WIDTH:
  - Go straight to DONE.
  - Result is 0 for SHL/SHR.
  - Result is WIDTH copies of in1's MSB for SRA.
- Shifts with in2 == 0 go straight to DONE; result is in1.
- Other shifts go to SHIFT. Each cycle shifts one bit and decrements the counter. Enter DONE when the counter reaches 0.
- DONE holds out_valid=1 with out_val and out_err stable until out_ready. On the handshake, return to IDLE.
- Flags are updated only at accept of ADD or SUB:
  - Z: result==0.
  - S: result MSB.
  - V: signed overflow.
  - C: carry-out for ADD; borrow (in1<in2 unsigned) for SUB.
- All other ops leave flags unchanged.
- Arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset values:
  - state is IDLE, so in_ready=1.
  - out_valid=0, out_val=0, out_err=0.
  - flags_q=0, so out_cond=0.
- Reset aborts any in-flight op immediately; its result is discarded.
- Latency from accept to out_valid rising:
  - 1 cycle for ADD/SUB/AND/XOR and for out-of-range or zero shifts.
  - n+1 cycles for a shift by n.
  - WIDTH+1 cycles for MUL.
- No overlap: a new request is accepted at the earliest one cycle after the output handshake.
- flags_q changes in the same edge that raises out_valid for the ADD/SUB that produced it.
- out_ready while out_valid=0 has no effect. in_valid while in_ready=0 is ignored, and the requester must hold it.

## Configuration
- ALU_MUL_EN defined:
  - Op 111 is an iterative shift-add multiply, one partial product per cycle for WIDTH cycles.
  - out_val is the low WIDTH bits of the product; out_err=0.
  - Flags are unchanged.
- ALU_MUL_EN undefined:
  - The MUL state and datapath are absent.
  - Op 111 completes with 1-cycle latency: out_val=0, out_err=1, flags unchanged.

## Structure
- Package alu_pkg holds:
  - the alu_op enum, the branch_sel enum, the FSM state enum;
  - flag bit-index constants (FLAG_Z=0, FLAG_S=1, FLAG_V=2, FLAG_C=3).
- One combinational sub-module, alu_arith: add/sub/AND/XOR plus Z/S/V/C generation, parametrised by WIDTH.
- Iterative shift and multiply logic live in alu_seq.

## Test plan
- ADD 10+15, WIDTH=8: out_val=25 one cycle after accept; flags_q=0000. Then SUB 20-5: out_val=15.
- SUB 5-5: Z=1, and branch_sel=00 gives out_cond=1. SUB 10-20: out_val=0xF6, S=1, C=1; branch_sel=01 gives out_cond=1.
- SUB 127-0xFF: out_val=0x80, V=1; branch_sel=10 gives out_cond=1. A following XOR 0xF0^0xAA gives out_val=0x5A with flags unchanged.
- Shifts:
  - SHL 3 by 2: out_val=12, out_valid exactly 3 cycles after accept.
  - SRA 0x80 by 3: out_val=0xF0.
  - SHR 0x0C by 9: out_val=0 after 1 cycle.
- Backpressure: hold out_ready=0 for 4 cycles. out_val stays stable, in_ready=0 and in_valid is ignored. After the handshake, in_ready=1 the next cycle.
- Reset asserted during SHIFT: out_valid=0 and flags_q=0 immediately; in_ready=1 after release. Then MUL 13*11:
  - with ALU_MUL_EN: out_val=0x8F after 9 cycles;
  - without it: out_err=1 and out_val=0 after 1 cycle.
